sound_sequencer: RTL and testbench
==================================

# sound_sequencer

Game-event sound sequencer for the Snake audio path. Converts one-cycle game event pulses (apple eaten, snake crashed) into a timed sequence of notes. It drives the `freq` and `playSound` inputs of the downstream oscillator stage. The oscillator then generates the tone, and this block decides which note plays, and when.

## Interface
Parameters:
- NOTE_CYCLES, default 1_000_000: clock cycles each note sounds; minimum 2.
- GAP_CYCLES, default 100_000: silent clock cycles between consecutive notes of one sequence; minimum 1.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- soundOn  input  1  global audio enable, level. When low, events are ignored and any active sequence aborts.
- eatEvent  input  1  one-cycle pulse: apple eaten.
- crashEvent  input  1  one-cycle pulse: snake crashed (game over).
- freq  output  8  registered note compare value for the oscillator.
- playSound  output  1  registered; high while a note sounds.
- busy  output  1  registered; high while a sequence is in progress (NOTE or GAP state).
- noteIdx  output  2  registered index of the current note within the active sequence.

## Operation
- Sequences are fixed in internal ROM:
  - EAT: 2 notes, freq 100 then 80.
  - CRASH: 4 notes, freq 120, 150, 180, 220.
- State machine has three states: IDLE, NOTE and GAP. Current sequence ID, noteIdx and a duration counter are held in registers.
- The duration counter width is clog2(max(NOTE_CYCLES, GAP_CYCLES)). The counter counts 0 up to limit−1, then the state advances.
- IDLE:
  - Outputs: freq=0, playSound=0, busy=0, noteIdx=0.
  - On soundOn=1 with any event: load the sequence, go to NOTE with noteIdx=0 and counter=0.
- NOTE:
  - Outputs: playSound=1, freq=ROM[seq][noteIdx].
  - When counter reaches NOTE_CYCLES−1: if this is the last note, go to IDLE; otherwise go to GAP with counter=0.
- GAP:
  - Outputs: playSound=0, freq holds the previous note's value.
  - When counter reaches GAP_CYCLES−1: increment noteIdx, go to NOTE with counter=0.
- Priority and preemption rules:
  - crashEvent and eatEvent in the same cycle: CRASH wins.
  - crashEvent during any EAT state: restart as CRASH from noteIdx 0.
  - eatEvent during EAT: restart EAT from noteIdx 0.
  - eatEvent during CRASH: ignored.
  - crashEvent during CRASH: ignored, so CRASH is never restarted.
- soundOn=0 in any state: go to IDLE on the next edge, with IDLE outputs. Events arriving in that cycle are dropped.
- Reset: IDLE, all outputs 0, counter 0, sequence ID = EAT (don't-care).

## Timing
- Event sampled at edge t: at t+1, playSound=1, busy=1 and freq holds the first note's value. Latency is one cycle.
- Each note keeps playSound=1 for exactly NOTE_CYCLES cycles.
- Each gap keeps playSound=0 for exactly GAP_CYCLES cycles, with busy still 1.
- busy is high for a total of N·NOTE_CYCLES + (N−1)·GAP_CYCLES cycles, where N is the number of notes in the sequence.
- After the last note: on the next edge, playSound=0, busy=0, freq=0.
- A retrigger at edge t forces noteIdx=0, counter=0 and the new sequence's first freq at t+1. playSound stays high with no glitch.
- Reset asserted mid-sequence forces all outputs to 0 immediately (asynchronous). Release resumes in IDLE.
- An event arriving in the same cycle the last note ends (IDLE transition edge) is accepted. It starts the new sequence at t+1 instead of entering IDLE.

## Test plan
Bench parameters: NOTE_CYCLES=4, GAP_CYCLES=2.
- Reset, then eatEvent with soundOn=1 -> busy=1 for 10 cycles. freq=100 with playSound=1 for 4 cycles, then 2 silent cycles, then freq=80 for 4 cycles, then freq=0, busy=0.
- crashEvent -> 4 notes (120, 150, 180, 220) at 4 cycles each with 2-cycle gaps. busy is high for exactly 22 cycles; noteIdx runs 0→3.
- eatEvent, then crashEvent 3 cycles later -> freq switches from 100 to 120 on the next cycle and playSound stays 1. The full 22-cycle CRASH sequence follows.
- eatEvent and crashEvent in the same cycle -> CRASH plays. A later eatEvent during CRASH is ignored: sequence and length are unchanged.
- Drop soundOn to 0 mid-note -> IDLE on the next cycle with all outputs 0. eatEvent while soundOn=0 -> no response.
- Assert rst during a GAP -> outputs go to 0 asynchronously. After release, eatEvent plays the normal 10-cycle EAT sequence.

Source files
------------

// File: rtl/sound_sequencer.sv
// Game-event sound sequencer: turns eat/crash pulses into timed note sequences
// that drive the downstream oscillator's freq/playSound inputs.
module sound_sequencer #(
  parameter int unsigned NOTE_CYCLES = 1_000_000,
  parameter int unsigned GAP_CYCLES  = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soundOn,
  input  logic       eatEvent,
  input  logic       crashEvent,
  output logic [7:0] freq,
  output logic       playSound,
  output logic       busy,
  output logic [1:0] noteIdx
);

  localparam int unsigned MaxCycles = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] NoteLast = CntW'(NOTE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StNote, StGap} state_e;
  typedef enum logic {SeqEat, SeqCrash} seq_e;

  state_e          state_q, state_d;
  seq_e            seq_q, seq_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      freq_q, freq_d;
  logic            play_q, play_d;
  logic            busy_q, busy_d;

  logic last_note, seq_done, can_take, start;

  function automatic logic [7:0] rom(input seq_e s, input logic [1:0] i);
    logic [7:0] f;
    f = 8'd0;
    if (s == SeqEat) begin
      f = (i == 2'd0) ? 8'd100 : 8'd80;
    end else begin
      unique case (i)
        2'd0:    f = 8'd120;
        2'd1:    f = 8'd150;
        2'd2:    f = 8'd180;
        default: f = 8'd220;
      endcase
    end
    return f;
  endfunction

  assign last_note = (seq_q == SeqEat) ? (idx_q == 2'd1) : (idx_q == 2'd3);
  assign seq_done  = (state_q == StNote) && (cnt_q == NoteLast) && last_note;
  // A running CRASH only yields on the edge its last note ends.
  assign can_take  = (state_q == StIdle) || (seq_q == SeqEat) || seq_done;
  assign start     = can_take && (eatEvent || crashEvent);

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    freq_d  = freq_q;
    play_d  = play_q;
    busy_d  = busy_q;
    if (!soundOn) begin
      state_d = StIdle;
      idx_d   = 2'd0;
      cnt_d   = '0;
      freq_d  = 8'd0;
      play_d  = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      seq_d   = crashEvent ? SeqCrash : SeqEat;
      state_d = StNote;
      idx_d   = 2'd0;
      cnt_d   = '0;
      freq_d  = rom(seq_d, 2'd0);
      play_d  = 1'b1;
      busy_d  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StNote: begin
          if (cnt_q == NoteLast) begin
            cnt_d  = '0;
            play_d = 1'b0;
            if (last_note) begin
              state_d = StIdle;
              idx_d   = 2'd0;
              freq_d  = 8'd0;
              busy_d  = 1'b0;
            end else begin
              state_d = StGap;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            state_d = StNote;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
            freq_d  = rom(seq_q, idx_q + 2'd1);
            play_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      seq_q   <= SeqEat;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      freq_q  <= 8'd0;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      play_q  <= play_d;
      busy_q  <= busy_d;
    end
  end

  assign freq      = freq_q;
  assign playSound = play_q;
  assign busy      = busy_q;
  assign noteIdx   = idx_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: vector table, hand-written corner
// sequences and random stimulus against a time-based reference model.
module tb_sound_sequencer;

  localparam int NC = 4;
  localparam int GC = 2;

  logic       clk = 1'b0;
  logic       rst, soundOn, eatEvent, crashEvent;
  logic [7:0] freq;
  logic       playSound, busy;
  logic [1:0] noteIdx;

  int n_cmp = 0;
  int n_bad = 0;

  sound_sequencer #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC)) dut (
    .clk        (clk),
    .rst        (rst),
    .soundOn    (soundOn),
    .eatEvent   (eatEvent),
    .crashEvent (crashEvent),
    .freq       (freq),
    .playSound  (playSound),
    .busy       (busy),
    .noteIdx    (noteIdx)
  );

  always #5 clk = ~clk;

  // Model: a sequence is a start point plus elapsed cycles; outputs follow by arithmetic.
  bit m_active = 0;
  bit m_crash  = 0;
  int m_e      = 0;

  function automatic int total(input bit c);
    int n;
    n = c ? 4 : 2;
    return n * NC + (n - 1) * GC;
  endfunction

  function automatic logic [7:0] note_f(input bit c, input int k);
    logic [7:0] eat_t[2];
    logic [7:0] crash_t[4];
    eat_t   = '{8'd100, 8'd80};
    crash_t = '{8'd120, 8'd150, 8'd180, 8'd220};
    return c ? crash_t[k] : eat_t[k];
  endfunction

  function automatic logic [11:0] model_out();
    int k, r;
    if (!m_active) return 12'd0;
    k = m_e / (NC + GC);
    r = m_e % (NC + GC);
    return {note_f(m_crash, k), (r < NC) ? 1'b1 : 1'b0, 1'b1, 2'(k)};
  endfunction

  task automatic model_edge(input bit s, input bit e, input bit c);
    bit open_w;
    open_w = !m_active || (m_e + 1 == total(m_crash));
    if (!s) begin
      m_active = 0;
    end else if (c && (open_w || !m_crash)) begin
      m_active = 1; m_crash = 1; m_e = 0;
    end else if (e && (open_w || !m_crash)) begin
      m_active = 1; m_crash = 0; m_e = 0;
    end else if (m_active) begin
      m_e++;
      if (m_e == total(m_crash)) m_active = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input bit s, input bit e, input bit c);
    soundOn    = s;
    eatEvent   = e;
    crashEvent = c;
    @(posedge clk);
    model_edge(s, e, c);
    @(negedge clk);
    eatEvent   = 1'b0;
    crashEvent = 1'b0;
    check("model {freq,play,busy,idx}", 32'({freq, playSound, busy, noteIdx}), 32'(model_out()));
  endtask

  typedef struct {
    bit         s;
    bit         e;
    bit         c;
    logic [7:0] f;
    bit         p;
    bit         b;
    logic [1:0] i;
  } vec_t;

  initial begin
    vec_t tbl[12];
    int   cnt;
    int   max_idx;

    tbl[0]  = '{1, 1, 0, 8'd100, 1, 1, 2'd0};
    tbl[1]  = '{1, 0, 0, 8'd100, 1, 1, 2'd0};
    tbl[2]  = '{1, 0, 0, 8'd100, 1, 1, 2'd0};
    tbl[3]  = '{1, 0, 0, 8'd100, 1, 1, 2'd0};
    tbl[4]  = '{1, 0, 0, 8'd100, 0, 1, 2'd0};
    tbl[5]  = '{1, 0, 0, 8'd100, 0, 1, 2'd0};
    tbl[6]  = '{1, 0, 0, 8'd80,  1, 1, 2'd1};
    tbl[7]  = '{1, 0, 0, 8'd80,  1, 1, 2'd1};
    tbl[8]  = '{1, 0, 0, 8'd80,  1, 1, 2'd1};
    tbl[9]  = '{1, 0, 0, 8'd80,  1, 1, 2'd1};
    tbl[10] = '{1, 0, 0, 8'd0,   0, 0, 2'd0};
    tbl[11] = '{0, 1, 0, 8'd0,   0, 0, 2'd0};

    rst = 1'b1; soundOn = 1'b0; eatEvent = 1'b0; crashEvent = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset outputs", 32'({freq, playSound, busy, noteIdx}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // EAT sequence from the vector table
    foreach (tbl[k]) begin
      tick(tbl[k].s, tbl[k].e, tbl[k].c);
      check($sformatf("table row %0d", k), 32'({freq, playSound, busy, noteIdx}),
            32'({tbl[k].f, tbl[k].p, tbl[k].b, tbl[k].i}));
    end

    // CRASH from idle: 22 busy cycles, noteIdx reaches 3
    tick(1, 0, 1);
    cnt = 0; max_idx = 0;
    for (int k = 0; k < 25; k++) begin
      if (busy) cnt++;
      if (int'(noteIdx) > max_idx) max_idx = int'(noteIdx);
      tick(1, 0, 0);
    end
    check("crash busy length", 32'(cnt), 32'd22);
    check("crash max noteIdx", 32'(max_idx), 32'd3);

    // EAT preempted by CRASH three cycles later
    tick(1, 1, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 1);
    check("preempt freq/play", 32'({freq, playSound}), 32'({8'd120, 1'b1}));
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (busy) cnt++;
      tick(1, 0, 0);
    end
    check("preempt crash length", 32'(cnt), 32'd22);

    // Simultaneous events: CRASH wins, later EAT ignored
    tick(1, 1, 1);
    check("priority freq", 32'(freq), 32'd120);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (busy) cnt++;
      tick(1, (k == 5), 0);
    end
    check("crash ignores eat length", 32'(cnt), 32'd22);

    // soundOn drop mid-note, then events while muted
    tick(1, 1, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    check("mute outputs", 32'({freq, playSound, busy, noteIdx}), 32'd0);
    tick(0, 1, 0);
    check("muted eat ignored", 32'({freq, playSound, busy, noteIdx}), 32'd0);
    tick(0, 0, 1);

    // Event on the edge the last EAT note ends restarts directly
    tick(1, 1, 0);
    for (int k = 0; k < 9; k++) tick(1, 0, 0);
    tick(1, 1, 0);
    check("end-edge retrigger", 32'({freq, playSound, busy, noteIdx}),
          32'({8'd100, 1'b1, 1'b1, 2'd0}));
    for (int k = 0; k < 12; k++) tick(1, 0, 0);

    // Async reset during a gap
    tick(1, 1, 0);
    for (int k = 0; k < 4; k++) tick(1, 0, 0);
    check("in gap before reset", 32'({playSound, busy}), 32'({1'b0, 1'b1}));
    #2 rst = 1'b1;
    #1 check("async reset outputs", 32'({freq, playSound, busy, noteIdx}), 32'd0);
    m_active = 0;
    @(negedge clk);
    rst = 1'b0;
    tick(1, 1, 0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy) cnt++;
      tick(1, 0, 0);
    end
    check("eat length after reset", 32'(cnt), 32'd10);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      tick(($urandom_range(0, 15) != 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
